// File: rtl/fpu_share_ctrl.sv
// Round-robin sharer of one FPU between two requesters; the result is captured FPU_LATENCY edges after accept.
// Requests stall (req_ready low) while an operation is in flight or its response has not been consumed.

module fpu_share_ctrl #(
  parameter int unsigned FPU_LATENCY = 4,
  parameter int unsigned WIDTH       = 32
) (
  input  logic               clock100KHz_i,
  input  logic               reset_i,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [2*WIDTH-1:0] req_a_i,
  input  logic [2*WIDTH-1:0] req_b_i,
  output logic [1:0]         rsp_valid_o,
  input  logic [1:0]         rsp_ready_i,
  output logic [WIDTH-1:0]   rsp_data_o,
  output logic [3:0]         rsp_status_o,
  output logic [WIDTH-1:0]   fpu_op_a_o,
  output logic [WIDTH-1:0]   fpu_op_b_o,
  input  logic [WIDTH-1:0]   fpu_data_in_i,
  input  logic [3:0]         fpu_status_in_i,
  output logic               busy_o,
  output logic [15:0]        op_count_o,
  output logic [7:0]         exc_count_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]       status;
    logic [WIDTH-1:0] data;
  } rsp_t;

  localparam logic [3:0] LAT = 4'(FPU_LATENCY);

  state_t           state_q;
  logic             rr_q;
  logic             owner_q;
  logic [3:0]       cnt_q;
  rsp_t             rsp_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             busy_q;
  logic [15:0]      op_count_q;
  logic [15:0]      op_count_d;
  logic [7:0]       exc_count_q;
  logic [7:0]       exc_count_d;

  logic             grant;
  logic             accept;
  logic             done;
  logic             exc_hit;

  // Favour rr only under contention; a lone requester always wins.
  assign grant = (&req_valid_i) ? rr_q : req_valid_i[1];

  always_comb begin
    req_ready_o = 2'b00;
    if (state_q == S_IDLE && !reset_i) begin
      req_ready_o[grant] = |req_valid_i;
    end
  end

  assign accept  = |(req_valid_i & req_ready_o);
  assign done    = (state_q == S_RESPOND) && rsp_ready_i[owner_q];
  assign exc_hit = rsp_q.status[2] | rsp_q.status[3];

  always_comb begin
    op_count_d  = op_count_q;
    exc_count_d = exc_count_q;
    if (done) begin
      op_count_d = op_count_q + 16'd1;
      if (exc_hit && (exc_count_q != 8'hFF)) begin
        exc_count_d = exc_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock100KHz_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      rsp_q       <= '0;
      rsp_valid_q <= 2'b00;
      op_a_q      <= '0;
      op_b_q      <= '0;
      busy_q      <= 1'b0;
      op_count_q  <= 16'd0;
      exc_count_q <= 8'd0;
    end else begin
      op_count_q  <= op_count_d;
      exc_count_q <= exc_count_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_a_q  <= grant ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
            op_b_q  <= grant ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
            owner_q <= grant;
            cnt_q   <= LAT;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // Operands have been stable for FPU_LATENCY edges once cnt reaches 1.
          if (cnt_q == 4'd1) begin
            rsp_q.data           <= fpu_data_in_i;
            rsp_q.status         <= fpu_status_in_i;
            rsp_valid_q[owner_q] <= 1'b1;
            state_q              <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (done) begin
            rsp_valid_q <= 2'b00;
            rr_q        <= ~owner_q;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_q.data;
  assign rsp_status_o = rsp_q.status;
  assign fpu_op_a_o   = op_a_q;
  assign fpu_op_b_o   = op_b_q;
  assign busy_o       = busy_q;
  assign op_count_o   = op_count_q;
  assign exc_count_o  = exc_count_q;

endmodule

// File: doc/fpu_share_ctrl.md
# fpu_share_ctrl

Sequencing and arbitration controller that shares one `fpu` instance between two requesters. It accepts operand pairs over valid/ready handshakes and picks a requester round-robin. It holds the operands stable on the FPU inputs for a fixed settling latency, then captures `data_out`/`status_out`. It returns the captured result and status to the originating requester over a second valid/ready handshake, and keeps operation and exception counters for debug.

## Interface
- `FPU_LATENCY`, default 4: cycles the FPU operands are held before the result is sampled; legal range 1..15.
- `WIDTH`, default 32: operand/result width (1 sign, 5 exponent, 26 mantissa bits; the controller treats data as opaque).
- `clock100KHz` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 2: bit i = requester i offers an operand pair.
- `req_ready` out 2: bit i = requester i's pair is accepted this cycle.
- `req_a` in 2*WIDTH: operand A; [WIDTH-1:0] = requester 0, [2*WIDTH-1:WIDTH] = requester 1.
- `req_b` in 2*WIDTH: operand B, same packing.
- `rsp_valid` out 2: bit i = result pending for requester i.
- `rsp_ready` in 2: bit i = requester i consumes the result.
- `rsp_data` out WIDTH: captured FPU result, shared by both requesters and qualified by `rsp_valid`.
- `rsp_status` out 4: captured FPU status, one-hot {UNDERFLOW, OVERFLOW, INEXACT, EXACT} = bits [3:0].
- `fpu_op_a` out WIDTH: registered operand A driven to the FPU `op_a_in`.
- `fpu_op_b` out WIDTH: registered operand B driven to the FPU `op_b_in`.
- `fpu_data_in` in WIDTH: FPU `data_out`.
- `fpu_status_in` in 4: FPU `status_out`.
- `busy` out 1: high in any state other than IDLE.
- `op_count` out 16: completed operations; wraps 0xFFFF→0.
- `exc_count` out 8: results with OVERFLOW or UNDERFLOW set; saturates at 0xFF.

## Operation
- The FSM has three states: IDLE, WAIT and RESPOND.
- **Round-robin pointer `rr`** (reset 0) names the favoured requester.
  - If both `req_valid` bits are high, grant `rr`.
  - If only one is high, grant that one.
- **IDLE:** `req_ready` is combinational: `req_ready[g] = 1` only for the granted g; all other bits are 0.
  - On an edge where `req_valid[g] && req_ready[g]`:
    - register `req_a`/`req_b` slice g into `fpu_op_a`/`fpu_op_b`;
    - set `owner` = g and `cnt` = FPU_LATENCY;
    - go to WAIT.
- **WAIT:** `req_ready` = 0. Decrement `cnt` each edge.
  - On the edge where `cnt` == 1:
    - capture `fpu_data_in` into `rsp_data` and `fpu_status_in` into `rsp_status`;
    - set `rsp_valid[owner]`;
    - go to RESPOND.
- **RESPOND:** hold `rsp_valid[owner]`, `rsp_data` and `rsp_status` stable until the edge where `rsp_ready[owner]` is high. On that edge:
  - clear `rsp_valid`;
  - set `rr` = ~owner;
  - increment `op_count`;
  - increment `exc_count` (saturating) if captured status bit 2 or bit 3 is set;
  - go to IDLE.
- `rsp_ready` of the non-owner is ignored. `req_valid` seen in WAIT or RESPOND is not accepted; the requester must hold it (standard valid/ready).
- `fpu_op_a`/`fpu_op_b` keep the last operands until the next accept; they never change in WAIT.
- A status that is not one-hot is passed through unchanged. It counts toward `exc_count` iff bit 2 or bit 3 is set.

## Timing
- **Reset values:** state IDLE, `rr` 0, `owner` 0, `cnt` 0; `req_ready` 0 while reset is high; `rsp_valid` 0, `rsp_data` 0, `rsp_status` 0, `fpu_op_a` 0, `fpu_op_b` 0, `busy` 0, `op_count` 0, `exc_count` 0.
- **Reset mid-operation** (WAIT or RESPOND): the in-flight result is discarded, no `rsp_valid` pulse occurs, and the counters clear.
- **Latency:** with the accept edge at E, `rsp_valid` rises after edge E+FPU_LATENCY. `rsp_data` equals `fpu_data_in` sampled at that edge.
- **Throughput:** minimum FPU_LATENCY+2 cycles per operation (1 IDLE + FPU_LATENCY WAIT + 1 RESPOND with `rsp_ready` already high).
- No combinational path from `fpu_data_in`/`fpu_status_in` to any output. The only combinational path is `req_valid` → `req_ready` in IDLE.
- `busy` is registered: high from the cycle after accept until the cycle after the response handshake.

## Test plan
1. **Single request.** Reset, FPU_LATENCY=4, `req_valid`=01 with A=0x12345678, B=0x0ABCDEF0 accepted at edge 10.
   - `fpu_op_a`=0x12345678 after edge 10.
   - Model drives 0xCAFEBABE with status 0001; `rsp_valid`=01 after edge 14, `rsp_data`=0xCAFEBABE, `rsp_status`=0001.
   - `rsp_ready[0]`=1 → `op_count`=1, `busy`=0 one cycle later.
2. **Contention.** `req_valid`=11 held continuously, `rsp_ready`=11.
   - Grants alternate 0,1,0,1 starting with 0.
   - Each `req_ready` pulse is exactly 1 cycle, spaced FPU_LATENCY+2 cycles apart.
3. **Backpressure.** `rsp_ready`=00 for 20 cycles after `rsp_valid`.
   - `rsp_data`/`rsp_status` stay constant.
   - `req_ready` stays 00 despite `req_valid`=10.
   - Requester 1 is accepted the cycle after `rsp_ready[owner]` rises.
4. **Exception counting.** 3 results with status 0100 (OVERFLOW), 2 with 1000 (UNDERFLOW), 1 with 0010 (INEXACT) → `exc_count`=5, `op_count`=6. Preload near saturation: 260 OVERFLOW results → `exc_count`=0xFF.
5. **Reset mid-WAIT.** Assert `reset` for 1 cycle two cycles after accept.
   - `rsp_valid` never rises; all outputs return to reset values.
   - The next request completes normally.
6. **Wrap.** Force `op_count`=0xFFFF, complete one operation → `op_count`=0x0000. FPU_LATENCY=1 → `rsp_valid` after accept edge +1.
